// File: rtl/omsp_spm_key_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : omsp_spm_key_loader_pkg
// Description : Shared key geometry and FSM state encodings for the SPM key
//               loader.
// Revision    : 1.0 - initial release
// ============================================================================
package omsp_spm_key_loader_pkg;

    localparam int SPM_KEY_WORDS = 8;
    localparam int SPM_KEY_W     = 128;

    typedef enum logic [1:0] {
        KL_IDLE   = 2'd0,
        KL_SELECT = 2'd1,
        KL_WRITE  = 2'd2
    } kl_state_e;

endpackage
`default_nettype wire

// File: rtl/omsp_spm_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : omsp_spm_key_loader
// Description : Initiator side of the SPM key-write interface. Selects the
//               target SPM, confirms the selection is valid, then streams the
//               latched key as KEY_WORDS words on write_key/key_in.
// Revision    : 1.0 - initial release
// ============================================================================
module omsp_spm_key_loader
    import omsp_spm_key_loader_pkg::*;
#(
    parameter int KEY_WORDS = SPM_KEY_WORDS,
    parameter int WORD_W    = 16
) (
    input  logic                          mclk,
    input  logic                          puc_rst,
    input  logic                          start,
    input  logic [15:0]                   spm_id,
    input  logic [0:KEY_WORDS*WORD_W-1]   key,
    input  logic                          abort,
    input  logic                          spm_key_select_valid,
    output logic [15:0]                   spm_key_select,
    output logic                          write_key,
    output logic [WORD_W-1:0]             key_in,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int KEY_BITS = KEY_WORDS * WORD_W;
    localparam int CNT_W    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(KEY_WORDS - 1);

    kl_state_e            state;
    kl_state_e            state_nxt;
    logic [15:0]          id_q;
    logic [0:KEY_BITS-1]  key_sr;     // index 0 is the MSB of the next word out
    logic [CNT_W-1:0]     word_cnt;

    // State register
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state <= KL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides validity and word count
    always_comb begin
        state_nxt = state;
        case (state)
            KL_IDLE:   if (start) state_nxt = KL_SELECT;
            KL_SELECT: begin
                if (abort || !spm_key_select_valid) state_nxt = KL_IDLE;
                else                                state_nxt = KL_WRITE;
            end
            KL_WRITE:  if (abort || (word_cnt == LAST_WORD)) state_nxt = KL_IDLE;
            default:   state_nxt = KL_IDLE;
        endcase
    end

    // Outputs decoded from registered state and registered datapath only
    always_comb begin
        busy           = (state != KL_IDLE);
        write_key      = (state == KL_WRITE);
        key_in         = (state == KL_WRITE) ? key_sr[0:WORD_W-1] : '0;
        spm_key_select = (state != KL_IDLE) ? id_q : 16'h0000;
    end

    // Key/id latch, word shifter, counter and terminal pulses; key material is
    // wiped whenever the transfer ends so nothing lingers in IDLE
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            id_q     <= 16'h0000;
            key_sr   <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                KL_IDLE: begin
                    if (start) begin
                        id_q     <= spm_id;
                        key_sr   <= key;
                        word_cnt <= '0;
                    end
                end
                KL_SELECT: begin
                    if (abort || !spm_key_select_valid) begin
                        error  <= 1'b1;
                        id_q   <= 16'h0000;
                        key_sr <= '0;
                    end
                end
                KL_WRITE: begin
                    key_sr <= key_sr << WORD_W;
                    if (abort) begin
                        error  <= 1'b1;
                        id_q   <= 16'h0000;
                        key_sr <= '0;
                    end else if (word_cnt == LAST_WORD) begin
                        done   <= 1'b1;
                        id_q   <= 16'h0000;
                        key_sr <= '0;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: begin
                    id_q   <= 16'h0000;
                    key_sr <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_omsp_spm_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_omsp_spm_key_loader
// Description : Directed self-checking bench for omsp_spm_key_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_omsp_spm_key_loader;
    import omsp_spm_key_loader_pkg::*;

    logic         mclk = 1'b0;
    logic         puc_rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  spm_id = 16'h0;
    logic [127:0] key = 128'h0;
    logic         abort = 1'b0;
    logic         valid_ok = 1'b0;
    logic         spm_key_select_valid;
    logic [15:0]  spm_key_select;
    logic         write_key;
    logic [15:0]  key_in;
    logic         busy;
    logic         done;
    logic         error;

    int checks = 0;
    int errors = 0;
    int writes;

    localparam logic [127:0] K1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] K2 = 128'hA5A5_0102_0304_0506_0708_090A_0B0C_F00D;

    // SPM control model: valid only when an id is actually presented
    assign spm_key_select_valid = valid_ok && (spm_key_select != 16'h0000);

    always #5 mclk = ~mclk;

    omsp_spm_key_loader dut (
        .mclk                 (mclk),
        .puc_rst              (puc_rst),
        .start                (start),
        .spm_id               (spm_id),
        .key                  (key),
        .abort                (abort),
        .spm_key_select_valid (spm_key_select_valid),
        .spm_key_select       (spm_key_select),
        .write_key            (write_key),
        .key_in               (key_in),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    function automatic logic [15:0] wd(input logic [127:0] k, input int n);
        return k[127-16*n -: 16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
        if (write_key === 1'b1) writes++;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sel"},   32'(spm_key_select), 32'h0);
        chk({tag, "_wr"},    32'(write_key),      32'h0);
        chk({tag, "_kin"},   32'(key_in),         32'h0);
        chk({tag, "_busy"},  32'(busy),           32'h0);
        chk({tag, "_done"},  32'(done),           32'h0);
        chk({tag, "_err"},   32'(error),          32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        #12;
        chk_idle_outputs("rst");
        chk("rst_state", 32'(dut.state), 32'(KL_IDLE));
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        tick();

        // ---------------- nominal ----------------
        writes = 0;
        start = 1'b1; spm_id = 16'h0003; key = K1; valid_ok = 1'b1;   // cycle 0
        chk("nom_c0_busy", 32'(busy), 32'h0);
        tick(); start = 1'b0; key = 128'h0;                            // cycle 1
        chk("nom_sel_busy", 32'(busy), 32'h1);
        chk("nom_sel_wr", 32'(write_key), 32'h0);
        chk("nom_sel_id", 32'(spm_key_select), 32'h0003);
        for (int i = 0; i < 8; i++) begin                              // cycles 2..9
            tick();
            chk("nom_wr", 32'(write_key), 32'h1);
            chk("nom_kin", 32'(key_in), 32'(wd(K1, i)));
            chk("nom_id", 32'(spm_key_select), 32'h0003);
            chk("nom_nodone", 32'(done), 32'h0);
        end
        tick();                                                        // cycle 10
        chk("nom_done", 32'(done), 32'h1);
        chk("nom_done_busy", 32'(busy), 32'h0);
        chk("nom_done_wr", 32'(write_key), 32'h0);
        chk("nom_done_sel", 32'(spm_key_select), 32'h0);
        chk("nom_done_kin", 32'(key_in), 32'h0);
        chk("nom_done_err", 32'(error), 32'h0);
        chk("nom_keyclr", 32'(dut.key_sr == '0), 32'h1);
        chk("nom_writes", 32'(writes), 32'd8);
        tick();
        chk("nom_done_pulse", 32'(done), 32'h0);

        // ---------------- invalid id ----------------
        writes = 0;
        start = 1'b1; spm_id = 16'h0009; key = K2; valid_ok = 1'b0;
        tick(); start = 1'b0;                                          // cycle 1
        chk("inv_sel_id", 32'(spm_key_select), 32'h0009);
        chk("inv_sel_wr", 32'(write_key), 32'h0);
        tick();                                                        // cycle 2
        chk("inv_err", 32'(error), 32'h1);
        chk("inv_busy", 32'(busy), 32'h0);
        chk("inv_sel0", 32'(spm_key_select), 32'h0);
        chk("inv_done", 32'(done), 32'h0);
        tick();
        chk("inv_err_pulse", 32'(error), 32'h0);
        chk("inv_writes", 32'(writes), 32'd0);

        // ---------------- abort during 4th word ----------------
        writes = 0; valid_ok = 1'b1;
        start = 1'b1; spm_id = 16'h0005; key = K2;
        tick(); start = 1'b0;                                          // cycle 1
        for (int c = 2; c <= 5; c++) tick();                           // cycle 5 = word 4
        chk("abt_kin4", 32'(key_in), 32'(wd(K2, 3)));
        abort = 1'b1;
        tick(); abort = 1'b0;                                          // cycle 6
        chk("abt_wr", 32'(write_key), 32'h0);
        chk("abt_err", 32'(error), 32'h1);
        chk("abt_done", 32'(done), 32'h0);
        chk("abt_busy", 32'(busy), 32'h0);
        tick(); tick();
        chk("abt_err_pulse", 32'(error), 32'h0);
        chk("abt_nodone", 32'(done), 32'h0);
        chk("abt_writes", 32'(writes), 32'd4);

        // ---------------- abort in idle ----------------
        abort = 1'b1;
        tick(); tick();
        abort = 1'b0;
        chk("idle_abt_err", 32'(error), 32'h0);
        chk("idle_abt_busy", 32'(busy), 32'h0);

        // ---------------- back-to-back / ignored start ----------------
        writes = 0;
        start = 1'b1; spm_id = 16'h0007; key = K1;                     // cycle 0
        tick(); start = 1'b0;                                          // cycle 1
        for (int c = 2; c <= 5; c++) tick();                           // cycle 5
        start = 1'b1; spm_id = 16'h00AA; key = K2;
        tick(); start = 1'b0;                                          // cycle 6, word 5
        chk("b2b_kin5", 32'(key_in), 32'(wd(K1, 4)));
        chk("b2b_sel6", 32'(spm_key_select), 32'h0007);
        for (int c = 7; c <= 9; c++) tick();                           // cycle 9
        chk("b2b_kin8", 32'(key_in), 32'(wd(K1, 7)));
        tick();                                                        // cycle 10
        chk("b2b_done", 32'(done), 32'h1);
        chk("b2b_writes", 32'(writes), 32'd8);
        start = 1'b1; spm_id = 16'h0008; key = K2;
        tick(); start = 1'b0;                                          // cycle 11
        chk("b2b2_busy", 32'(busy), 32'h1);
        chk("b2b2_sel", 32'(spm_key_select), 32'h0008);
        chk("b2b2_selwr", 32'(write_key), 32'h0);
        tick();                                                        // cycle 12
        chk("b2b2_wr", 32'(write_key), 32'h1);
        chk("b2b2_kin0", 32'(key_in), 32'(wd(K2, 0)));
        for (int c = 13; c <= 20; c++) tick();                         // cycle 20
        chk("b2b2_done", 32'(done), 32'h1);

        // ---------------- reset mid-write ----------------
        start = 1'b1; spm_id = 16'h0004; key = K1;
        tick(); start = 1'b0;                                          // cycle 1
        for (int c = 2; c <= 7; c++) tick();                           // cycle 7 = word 6
        chk("rstm_kin6", 32'(key_in), 32'(wd(K1, 5)));
        puc_rst = 1'b1;
        #1;
        chk_idle_outputs("rstm");
        chk("rstm_state", 32'(dut.state), 32'(KL_IDLE));
        tick(); tick();
        puc_rst = 1'b0;
        tick();
        chk("rstm_after_done", 32'(done), 32'h0);
        chk("rstm_after_err", 32'(error), 32'h0);

        // ---------------- abort with last word ----------------
        writes = 0;
        start = 1'b1; spm_id = 16'h0002; key = K2;
        tick(); start = 1'b0;                                          // cycle 1
        for (int c = 2; c <= 9; c++) tick();                           // cycle 9 = word 8
        chk("abtl_kin8", 32'(key_in), 32'(wd(K2, 7)));
        abort = 1'b1;
        tick(); abort = 1'b0;                                          // cycle 10
        chk("abtl_err", 32'(error), 32'h1);
        chk("abtl_done", 32'(done), 32'h0);
        chk("abtl_writes", 32'(writes), 32'd8);
        tick();
        chk("abtl_err_pulse", 32'(error), 32'h0);
        chk("abtl_nodone", 32'(done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
